// File: rtl/eth_pkg.sv
// Shared constants and types for the GMII transmit scheduler.
package eth_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int unsigned DEFAULT_IFG_BYTES       = 12;
  localparam int unsigned DEFAULT_PREAMBLE_BYTES  = 7;
  localparam int unsigned DEFAULT_MAX_FRAME_BYTES = 1518;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    ABORT,
    DRAIN,
    IFG
  } tx_state_t;

  // Larger of two sizes, used to dimension shared counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The pointer selects the preferred requester on a tie
// (0 prefers req_i[0]) and, on advance_i, moves to the requester not currently granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // Grant: pass single requests straight through, break ties with the pointer.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Pointer next state: after serving s0 prefer s1, and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (gnt_o != 2'b00)) begin
      ptr_d = gnt_o[0];
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gmii_tx_sched.sv
// Shares one GMII transmit datapath between two byte-stream sources: round-robin arbitration,
// preamble/SFD insertion, inter-frame gap, and tx_er signalling on underrun or oversize.
// The state register tracks what is on the wire: the first data byte is fetched during the SFD
// cycle so the frame stays contiguous, and the last byte is shown in a DATA tail cycle.
module gmii_tx_sched
  import eth_pkg::*;
#(
  parameter int unsigned IFG_BYTES       = DEFAULT_IFG_BYTES,
  parameter int unsigned PREAMBLE_BYTES  = DEFAULT_PREAMBLE_BYTES,
  parameter int unsigned MAX_FRAME_BYTES = DEFAULT_MAX_FRAME_BYTES
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] s0_tdata,
  input  logic       s0_tvalid,
  input  logic       s0_tlast,
  output logic       s0_tready,
  input  logic [7:0] s1_tdata,
  input  logic       s1_tvalid,
  input  logic       s1_tlast,
  output logic       s1_tready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [1:0] grant,
  output logic       busy,
  output logic       err_pulse
);

  localparam int unsigned CntW = $clog2(MAX_FRAME_BYTES + 1);
  localparam int unsigned PhW  = $clog2(max_u(PREAMBLE_BYTES, IFG_BYTES) + 1);

  tx_state_t        state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [CntW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [PhW-1:0]   ph_cnt_q, ph_cnt_d;
  logic             last_seen_q, last_seen_d;
  logic [7:0]       txd_q, txd_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;
  logic             err_q, err_d;

  logic [7:0]       sel_tdata;
  logic             sel_tvalid;
  logic             sel_tlast;
  logic             take;
  logic             hs;
  logic             at_max;
  logic [1:0]       arb_req;
  logic [1:0]       arb_gnt;
  logic             arb_advance;

  // Arbitration only looks at live requests in IDLE; afterwards it sees the owner so the
  // pointer can step past it on IFG entry.
  always_comb begin
    arb_req     = (state_q == IDLE) ? {s1_tvalid, s0_tvalid} : owner_q;
    arb_advance = (state_d == IFG) && (state_q != IFG);
  end

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rstn      (rstn),
    .req_i     (arb_req),
    .advance_i (arb_advance),
    .gnt_o     (arb_gnt)
  );

  // Mux the owning source and decide when it may hand over a byte.
  always_comb begin
    sel_tdata  = owner_q[1] ? s1_tdata  : s0_tdata;
    sel_tvalid = owner_q[1] ? s1_tvalid : s0_tvalid;
    sel_tlast  = owner_q[1] ? s1_tlast  : s0_tlast;
    at_max     = (byte_cnt_q == CntW'(MAX_FRAME_BYTES));
    take       = 1'b0;
    unique case (state_q)
      SFD:     take = 1'b1;
      DATA:    take = !last_seen_q && !at_max;
      DRAIN:   take = 1'b1;
      default: take = 1'b0;
    endcase
    hs        = take && sel_tvalid;
    s0_tready = take && owner_q[0];
    s1_tready = take && owner_q[1];
  end

  // Next-state logic plus the values the output registers load for the next wire cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    byte_cnt_d  = byte_cnt_q;
    ph_cnt_d    = ph_cnt_q;
    last_seen_d = last_seen_q;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          owner_d     = arb_gnt;
          byte_cnt_d  = '0;
          ph_cnt_d    = '0;
          last_seen_d = 1'b0;
          state_d     = PRE;
        end
      end
      PRE: begin
        if (ph_cnt_q == PhW'(PREAMBLE_BYTES - 1)) begin
          state_d = SFD;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      SFD: begin
        if (hs) begin
          byte_cnt_d  = byte_cnt_q + 1'b1;
          last_seen_d = sel_tlast;
          state_d     = DATA;
        end else begin
          state_d = ABORT;
        end
      end
      DATA: begin
        if (last_seen_q) begin
          state_d = IFG;
        end else if (at_max) begin
          state_d = ABORT;
        end else if (hs) begin
          byte_cnt_d  = byte_cnt_q + 1'b1;
          last_seen_d = sel_tlast;
        end else begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        state_d = last_seen_q ? IFG : DRAIN;
      end
      DRAIN: begin
        if (hs && sel_tlast) begin
          state_d = IFG;
        end
      end
      IFG: begin
        if (ph_cnt_q == PhW'(IFG_BYTES - 1)) begin
          state_d = IDLE;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_advance) begin
      ph_cnt_d = '0;
    end

    unique case (state_d)
      PRE: begin
        txd_d   = PREAMBLE_BYTE;
        tx_en_d = 1'b1;
      end
      SFD: begin
        txd_d   = SFD_BYTE;
        tx_en_d = 1'b1;
      end
      // Entering or staying in DATA always coincides with a handshake.
      DATA: begin
        txd_d   = sel_tdata;
        tx_en_d = 1'b1;
      end
      ABORT: begin
        tx_en_d = 1'b1;
        tx_er_d = 1'b1;
        err_d   = 1'b1;
      end
      default: begin
        txd_d   = 8'h00;
        tx_en_d = 1'b0;
      end
    endcase
  end

  // State and registered GMII outputs; reset clears the wire immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      owner_q     <= 2'b00;
      byte_cnt_q  <= '0;
      ph_cnt_q    <= '0;
      last_seen_q <= 1'b0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      byte_cnt_q  <= byte_cnt_d;
      ph_cnt_q    <= ph_cnt_d;
      last_seen_q <= last_seen_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      err_q       <= err_d;
    end
  end

  // Status outputs derived from the state register.
  always_comb begin
    gmii_txd   = txd_q;
    gmii_tx_en = tx_en_q;
    gmii_tx_er = tx_er_q;
    err_pulse  = err_q;
    busy       = (state_q != IDLE);
    grant      = ((state_q == IDLE) || (state_q == IFG)) ? 2'b00 : owner_q;
  end

endmodule
